// File: rtl/usb_frame_arbiter.sv
// rtl/usb_frame_arbiter.sv - round-robin framer sharing one USB byte stream between packet sources
//
// Purpose: grants one requesting source at a time (round-robin), emits a
// header byte 0xA0|index, then forwards the source's packet bytes as one
// frame. A frame that sees TIMEOUT consecutive idle cycles is aborted.
//
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset
//   req_i          per-source packet pending (sampled in IDLE only)
//   data_i         per-source byte, source i at [i*DATA_W +: DATA_W]
//   valid_i        per-source byte valid
//   last_i         per-source final byte of packet
//   ready_o        per-source accept strobe (granted source, STREAM only)
//   data_o         output byte, 0 when valid_o is low
//   valid_o        output byte valid
//   frame_o        high from header byte to last byte inclusive
//   grant_o        one-hot owner of the active frame
//   abort_o        one-cycle pulse on timeout abort
//   abort_cnt_o    saturating count of aborted frames

module usb_frame_arbiter #(
  parameter int NB_REQ  = 4,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 64
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NB_REQ-1:0]        req_i,
  input  logic [NB_REQ*DATA_W-1:0] data_i,
  input  logic [NB_REQ-1:0]        valid_i,
  input  logic [NB_REQ-1:0]        last_i,
  output logic [NB_REQ-1:0]        ready_o,
  output logic [DATA_W-1:0]        data_o,
  output logic                     valid_o,
  output logic                     frame_o,
  output logic [NB_REQ-1:0]        grant_o,
  output logic                     abort_o,
  output logic [7:0]               abort_cnt_o
);

  localparam int IW = (NB_REQ > 1) ? $clog2(NB_REQ) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_HEADER = 2'd1;
  localparam logic [1:0] ST_STREAM = 2'd2;
  localparam logic [1:0] ST_GAP    = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [NB_REQ-1:0] grant_q, grant_d;
  logic [IW-1:0]     last_grant_q, last_grant_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              frame_q, frame_d;
  logic              abort_q, abort_d;
  logic [7:0]        abort_cnt_q, abort_cnt_d;
  logic [CW-1:0]     idle_q, idle_d;

  logic              pick_found;
  logic [IW-1:0]     pick_idx;
  logic [IW-1:0]     cand;
  logic              xfer;
  logic [DATA_W-1:0] gnt_data;

  // Search starts one past the previous winner so every source gets a turn.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = last_grant_q;
    cand       = last_grant_q;
    for (int i = 1; i <= NB_REQ; i++) begin
      cand = IW'((int'(last_grant_q) + i) % NB_REQ);
      if (!pick_found && req_i[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // last_grant_q holds the index of the current owner for the whole frame,
  // so it doubles as the mux select for the granted source's signals.
  assign xfer     = (state_q == ST_STREAM) && valid_i[last_grant_q];
  assign gnt_data = data_i[last_grant_q*DATA_W +: DATA_W];

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    data_d       = '0;
    valid_d      = 1'b0;
    frame_d      = frame_q;
    abort_d      = 1'b0;
    abort_cnt_d  = abort_cnt_q;
    idle_d       = idle_q;
    case (state_q)
      ST_IDLE: begin
        frame_d = 1'b0;
        grant_d = '0;
        if (pick_found) begin
          grant_d      = NB_REQ'(1) << pick_idx;
          last_grant_d = pick_idx;
          data_d       = DATA_W'(8'hA0) | DATA_W'(pick_idx);
          valid_d      = 1'b1;
          frame_d      = 1'b1;
          state_d      = ST_HEADER;
        end
      end
      ST_HEADER: begin
        frame_d = 1'b1;
        idle_d  = '0;
        state_d = ST_STREAM;
      end
      ST_STREAM: begin
        if (xfer) begin
          data_d  = gnt_data;
          valid_d = 1'b1;
          frame_d = 1'b1;
          idle_d  = '0;
          if (last_i[last_grant_q]) state_d = ST_GAP;
        end else if (idle_q == CW'(TIMEOUT - 1)) begin
          // Frame ends here; GAP then only re-applies the zeroed outputs,
          // which yields the two-cycle low gap after an abort.
          frame_d = 1'b0;
          abort_d = 1'b1;
          if (abort_cnt_q != 8'hFF) abort_cnt_d = abort_cnt_q + 8'd1;
          state_d = ST_GAP;
        end else begin
          frame_d = 1'b1;
          idle_d  = idle_q + 1'b1;
        end
      end
      default: begin
        frame_d = 1'b0;
        grant_d = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_grant_q <= IW'(NB_REQ - 1);
      data_q       <= '0;
      valid_q      <= 1'b0;
      frame_q      <= 1'b0;
      abort_q      <= 1'b0;
      abort_cnt_q  <= '0;
      idle_q       <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      frame_q      <= frame_d;
      abort_q      <= abort_d;
      abort_cnt_q  <= abort_cnt_d;
      idle_q       <= idle_d;
    end
  end

  assign ready_o     = (state_q == ST_STREAM) ? grant_q : '0;
  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign frame_o     = frame_q;
  assign grant_o     = grant_q;
  assign abort_o     = abort_q;
  assign abort_cnt_o = abort_cnt_q;

endmodule
